// File: rtl/adc_decimator.sv
// adc_decimator: block-averaging decimator for 12-bit ADC conversions.
// Optional feature macro: ADC_DECIMATOR_SIGNED_EN (offset-binary to two's complement output).
module adc_decimator #(
  parameter int DATA_WIDTH = 12,
  parameter int DECIM_LOG2 = 2,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ack,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int AW = DATA_WIDTH + DECIM_LOG2;
  localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << DECIM_LOG2) - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t               state, state_n;
  logic [AW-1:0]        acc, acc_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [OUT_WIDTH-1:0] od_n;
  logic                 ov_n;
  logic                 orun_n;

  logic [AW-1:0]         sum;
  logic [DATA_WIDTH-1:0] mean;
  logic [OUT_WIDTH-1:0]  fmt;
  logic                  complete;

  assign sum  = acc + AW'(in_data);
  assign mean = DATA_WIDTH'(sum >> DECIM_LOG2);

`ifdef ADC_DECIMATOR_SIGNED_EN
  // Subtracting midscale is just an MSB flip; the cast sign-extends.
  logic signed [DATA_WIDTH-1:0] off;
  assign off = {~mean[DATA_WIDTH-1], mean[DATA_WIDTH-2:0]};
  assign fmt = OUT_WIDTH'(off);
`else
  // Unsigned mean, zero-extended.
  assign fmt = OUT_WIDTH'(mean);
`endif

  assign complete = (state == ACCUM) && in_valid && (cnt == CNT_MAX);

  // Next-state, accumulator and handshake logic.
  always_comb begin
    state_n = enable ? ACCUM : IDLE;
    acc_n   = acc;
    cnt_n   = cnt;
    od_n    = out_data;
    ov_n    = out_valid;
    orun_n  = overrun;
    unique case (state)
      IDLE: begin
        acc_n = '0;
        cnt_n = '0;
      end
      ACCUM: begin
        if (complete) begin
          acc_n = '0;
          cnt_n = '0;
          od_n  = fmt;
        end else if (in_valid) begin
          acc_n = sum;
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        acc_n = '0;
        cnt_n = '0;
      end
    endcase
    if (complete) begin
      ov_n = 1'b1;
    end else if (out_valid && out_ack) begin
      ov_n = 1'b0;
    end
    if (complete && out_valid && !out_ack) begin
      orun_n = 1'b1;
    end else if (overrun_clr) begin
      orun_n = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      out_data  <= od_n;
      out_valid <= ov_n;
      overrun   <= orun_n;
    end
  end

endmodule

// File: tb/tb_adc_decimator.sv
// tb_adc_decimator: directed table-driven bench for adc_decimator.
// Expected output format follows ADC_DECIMATOR_SIGNED_EN when defined.
module tb_adc_decimator;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [11:0] in_data;
  logic        in_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ack;
  logic        overrun;
  logic        overrun_clr;

  int checks = 0;
  int errors = 0;

  adc_decimator dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d [4];
    int          mean;
  } vec_t;

  function automatic logic [15:0] fmt(input int mean);
    int v;
`ifdef ADC_DECIMATOR_SIGNED_EN
    v = mean - 2048;
`else
    v = mean;
`endif
    return v[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [11:0] d);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{d: '{12'd100, 12'd200, 12'd300, 12'd404}, mean: 251};
    vecs[1] = '{d: '{12'd0, 12'd0, 12'd0, 12'd0}, mean: 0};
    vecs[2] = '{d: '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, mean: 4095};
    vecs[3] = '{d: '{12'd1, 12'd2, 12'd3, 12'd4}, mean: 2};
    vecs[4] = '{d: '{12'd3, 12'd0, 12'd0, 12'd0}, mean: 0};
    vecs[5] = '{d: '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFE}, mean: 4094};
    vecs[6] = '{d: '{12'h800, 12'h800, 12'h800, 12'h800}, mean: 2048};

    rst = 1'b1;
    enable = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    out_ack = 1'b0;
    overrun_clr = 1'b0;
    #12;
    check("rst_data", out_data, 16'h0);
    check("rst_valid", {15'b0, out_valid}, 16'h0);
    check("rst_overrun", {15'b0, overrun}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 4; j++) strobe(vecs[i].d[j]);
      check($sformatf("vec%0d_valid", i), {15'b0, out_valid}, 16'h1);
      check($sformatf("vec%0d_data", i), out_data, fmt(vecs[i].mean));
      check($sformatf("vec%0d_ovr", i), {15'b0, overrun}, 16'h0);
      ack();
      check($sformatf("vec%0d_acked", i), {15'b0, out_valid}, 16'h0);
    end

    for (int j = 0; j < 4; j++) strobe(12'd1);
    check("ovr_first_valid", {15'b0, out_valid}, 16'h1);
    check("ovr_first_data", out_data, fmt(1));
    for (int j = 0; j < 4; j++) strobe(12'd5);
    check("ovr_data", out_data, fmt(5));
    check("ovr_set", {15'b0, overrun}, 16'h1);
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clr", {15'b0, overrun}, 16'h0);
    check("ovr_clr_valid", {15'b0, out_valid}, 16'h1);

    for (int j = 0; j < 3; j++) strobe(12'd9);
    @(negedge clk);
    in_data = 12'd13;
    in_valid = 1'b1;
    out_ack = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ack = 1'b0;
    check("coack_valid", {15'b0, out_valid}, 16'h1);
    check("coack_data", out_data, fmt(10));
    check("coack_ovr", {15'b0, overrun}, 16'h0);
    ack();

    strobe(12'd7);
    strobe(12'd7);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("dis_valid", {15'b0, out_valid}, 16'h0);
    enable = 1'b1;
    in_data = 12'd100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) strobe(12'd8);
    check("reen_partial", {15'b0, out_valid}, 16'h0);
    strobe(12'd8);
    check("reen_valid", {15'b0, out_valid}, 16'h1);
    check("reen_data", out_data, fmt(8));
    ack();

    for (int j = 0; j < 4; j++) strobe(12'd20);
    for (int j = 0; j < 4; j++) strobe(12'd30);
    for (int j = 0; j < 3; j++) strobe(12'd30);
    check("pre_rst_ovr", {15'b0, overrun}, 16'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_data", out_data, 16'h0);
    check("arst_valid", {15'b0, out_valid}, 16'h0);
    check("arst_ovr", {15'b0, overrun}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 4; j++) strobe(12'd40);
    check("post_rst_valid", {15'b0, out_valid}, 16'h1);
    check("post_rst_data", out_data, fmt(40));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
